// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write-port arbiter with a registered write port.
// Define REGFILE_CLEAR_EN to add a 32-cycle zeroing sweep of the register file after reset.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int DATA_W         = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  input  logic [4:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [4:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              writeEnable,
  output logic [4:0]        writeAddress,
  output logic [DATA_W-1:0] writeData,
  output logic              initDone
);

  typedef enum logic {INIT, ARB} state_t;

  state_t state, state_next;
`ifdef REGFILE_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
  logic [5:0] clr_cnt;
`else
  localparam state_t RESET_STATE = ARB;
`endif

  logic              last_grant;   // 1: requester 1 won most recently
  logic              init_done_p1;
  logic              live;
  logic              grant0, grant1;
  logic              wr_en_p1;
  logic [4:0]        wr_addr_p1;
  logic [DATA_W-1:0] wr_data_p1;

  // Arbitration only runs once the block reports itself live, which also masks
  // the readies during reset and the first cycle after release.
  assign live = (state == ARB) && init_done_p1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (live) begin
      if (req0_valid && req1_valid) begin
        if (FIXED_PRIORITY != 0) grant0 = 1'b1;
        else if (last_grant)     grant0 = 1'b1;
        else                     grant1 = 1'b1;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_next = state;
`ifdef REGFILE_CLEAR_EN
    if (state == INIT && clr_cnt == 6'd32) state_next = ARB;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= RESET_STATE;
    else     state <= state_next;
  end

  // Stage p0 -> p1: accepted transfer (or sweep step) lands in the write-port registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_en_p1     <= 1'b0;
      wr_addr_p1   <= 5'd0;
      wr_data_p1   <= '0;
      last_grant   <= 1'b1;
      init_done_p1 <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      clr_cnt      <= 6'd0;
`endif
    end else begin
      wr_en_p1 <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      if (state == INIT) begin
        if (clr_cnt != 6'd32) begin
          wr_en_p1   <= 1'b1;
          wr_addr_p1 <= clr_cnt[4:0];
          wr_data_p1 <= '0;
          clr_cnt    <= clr_cnt + 6'd1;
        end else begin
          init_done_p1 <= 1'b1;
        end
      end else
`endif
      begin
        init_done_p1 <= 1'b1;
        // A write to $zero is consumed but never reaches the register file.
        if (grant0) begin
          last_grant <= 1'b0;
          if (req0_addr != 5'd0) begin
            wr_en_p1   <= 1'b1;
            wr_addr_p1 <= req0_addr;
            wr_data_p1 <= req0_data;
          end
        end else if (grant1) begin
          last_grant <= 1'b1;
          if (req1_addr != 5'd0) begin
            wr_en_p1   <= 1'b1;
            wr_addr_p1 <= req1_addr;
            wr_data_p1 <= req1_data;
          end
        end
      end
    end
  end

  assign writeEnable  = wr_en_p1;
  assign writeAddress = wr_addr_p1;
  assign writeData    = wr_data_p1;
  assign initDone     = init_done_p1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a randomized
// run against a transaction-level model; a second instance covers fixed priority.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        r0v, r1v, r0r, r1r, we, idn;
  logic [4:0]  r0a, r1a, wa;
  logic [31:0] r0d, r1d, wd;
  logic        f0v, f1v, f0r, f1r, fwe, fidn;
  logic [4:0]  f0a, f1a, fwa;
  logic [31:0] f0d, f1d, fwd;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.FIXED_PRIORITY(0), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1r),
    .writeEnable(we), .writeAddress(wa), .writeData(wd), .initDone(idn)
  );

  regfile_write_arbiter #(.FIXED_PRIORITY(1), .DATA_W(32)) dut_fp (
    .CLK(CLK), .RST(RST),
    .req0_valid(f0v), .req0_addr(f0a), .req0_data(f0d), .req0_ready(f0r),
    .req1_valid(f1v), .req1_addr(f1a), .req1_data(f1d), .req1_ready(f1r),
    .writeEnable(fwe), .writeAddress(fwa), .writeData(fwd), .initDone(fidn)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bit ok;
    ok = 1'b0;
    r0v = 0; r1v = 0; f0v = 0; f1v = 0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge CLK); #1;
      if (idn === 1'b1 && fidn === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_wait: initDone got %b/%b required 1/1", idn, fidn);
    end
  endtask

  task automatic test_reset();
    r0v = 1; r0a = 5'd3; r0d = 32'h11; r1v = 1; r1a = 5'd4; r1d = 32'h22;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || idn !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got we=%b addr=%0d data=%h init=%b rdy=%b%b required all 0",
               we, wa, wd, idn, r0r, r1r);
    end
    r0v = 0; r1v = 0;
`ifndef REGFILE_CLEAR_EN
    RST = 1'b0;
    checks++;
    if (idn !== 1'b0 || r0r !== 1'b0) begin
      errors++;
      $display("FAIL init_before_edge: got initDone=%b required 0", idn);
    end
    @(posedge CLK); #1;
    checks++;
    if (idn !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL init_first_edge: got initDone=%b we=%b required 1,0", idn, we);
    end
`endif
  endtask

`ifdef REGFILE_CLEAR_EN
  // Precondition: RST released at posedge+1.
  task automatic sweep_check();
    r0v = 1; r0a = 5'd3; r0d = 32'h33; r1v = 1; r1a = 5'd4; r1d = 32'h44;
    @(posedge CLK); #1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (we !== 1'b1 || wa !== i[4:0] || wd !== 32'd0 || idn !== 1'b0 || r0r !== 1'b0 || r1r !== 1'b0) begin
        errors++;
        $display("FAIL sweep_%0d: got we=%b addr=%0d data=%h init=%b rdy=%b%b required 1,%0d,0,0,00",
                 i, we, wa, wd, idn, r0r, r1r, i);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (we !== 1'b0 || idn !== 1'b1 || r0r !== 1'b1 || r1r !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: got we=%b init=%b rdy=%b%b required 0,1,10", we, idn, r0r, r1r);
    end
    r0v = 0; r1v = 0;
  endtask

  task automatic test_sweep();
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    sweep_check();
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge CLK); #1;
      if (we === 1'b1 && wa === 5'd10) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_sweep_reach: got addr=%0d required 10", wa);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (we !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || idn !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_abort: got we=%b addr=%0d data=%h init=%b required 0", we, wa, wd, idn);
    end
    @(posedge CLK); #1 RST = 1'b0;
    sweep_check();
  endtask
`else
  task automatic test_reset_mid();
    do_reset();
    r0v = 1; r0a = 5'd9; r0d = 32'hCAFE0009;
    #1;
    checks++;
    if (r0r !== 1'b1) begin
      errors++;
      $display("FAIL mid_xfer_ready: got %b required 1", r0r);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (r0r !== 1'b0 || we !== 1'b0 || idn !== 1'b0) begin
      errors++;
      $display("FAIL mid_xfer_abort: got rdy=%b we=%b init=%b required 0", r0r, we, idn);
    end
    r0v = 0;
    @(posedge CLK); #1 RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (we !== 1'b0) begin
        errors++;
        $display("FAIL mid_xfer_nowrite_%0d: got we=%b required 0", k, we);
      end
    end
  endtask
`endif

  task automatic test_single();
    do_reset();
    r0v = 1; r0a = 5'd5; r0d = 32'hDEADBEEF;
    #1;
    checks++;
    if (r0r !== 1'b1 || r1r !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b required 10", r0r, r1r);
    end
    @(posedge CLK); #1;
    r0v = 0;
    checks++;
    if (we !== 1'b1 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h required 1,5,deadbeef", we, wa, wd);
    end
    @(posedge CLK); #1;
    checks++;
    if (we !== 1'b0 || wa !== 5'd5 || wd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL idle_hold: got we=%b addr=%0d data=%h required 0,5,deadbeef", we, wa, wd);
    end
  endtask

  task automatic test_zero_addr();
    do_reset();
    r1v = 1; r1a = 5'd0; r1d = 32'h1234;
    #1;
    checks++;
    if (r1r !== 1'b1 || r0r !== 1'b0) begin
      errors++;
      $display("FAIL zero_ready: got %b%b required 01", r0r, r1r);
    end
    @(posedge CLK); #1;
    r1v = 0;
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL zero_write: got we=%b required 0", we);
    end
  endtask

  task automatic test_round_robin();
    int exp_g [4] = '{0, 1, 0, 1};
    int g;
    do_reset();
    r0v = 1; r0a = 5'd1; r0d = 32'hA000;
    r1v = 1; r1a = 5'd17; r1d = 32'hB000;
    for (int c = 0; c < 4; c++) begin
      #1;
      g = (r0r === 1'b1 && r1r === 1'b0) ? 0 : ((r1r === 1'b1 && r0r === 1'b0) ? 1 : -1);
      checks++;
      if (g != exp_g[c]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %0d required %0d", c, g, exp_g[c]);
      end
      @(posedge CLK); #1;
      checks++;
      if (exp_g[c] == 0) begin
        if (we !== 1'b1 || wa !== r0a || wd !== r0d) begin
          errors++;
          $display("FAIL rr_write_%0d: got addr=%0d data=%h required %0d,%h", c, wa, wd, r0a, r0d);
        end
        r0a = r0a + 5'd1; r0d = r0d + 32'd1;
      end else begin
        if (we !== 1'b1 || wa !== r1a || wd !== r1d) begin
          errors++;
          $display("FAIL rr_write_%0d: got addr=%0d data=%h required %0d,%h", c, wa, wd, r1a, r1d);
        end
        r1a = r1a + 5'd1; r1d = r1d + 32'd1;
      end
    end
    r0v = 0; r1v = 0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    f0v = 1; f0a = 5'd2; f0d = 32'hC000;
    f1v = 1; f1a = 5'd20; f1d = 32'hD000;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (f0r !== 1'b1 || f1r !== 1'b0) begin
        errors++;
        $display("FAIL fp_grant_%0d: got %b%b required 10", c, f0r, f1r);
      end
      @(posedge CLK); #1;
      checks++;
      if (fwe !== 1'b1 || fwa !== f0a || fwd !== f0d) begin
        errors++;
        $display("FAIL fp_write_%0d: got addr=%0d data=%h required %0d,%h", c, fwa, fwd, f0a, f0d);
      end
      f0a = f0a + 5'd1; f0d = f0d + 32'd1;
    end
    f0v = 0; f1v = 0;
  endtask

  // Requesters keep a pending write until accepted; the model grants per the
  // arbitration rules and predicts the registered write port one cycle later.
  task automatic test_back_to_back();
    bit          p0, p1, xw;
    logic [4:0]  xa;
    logic [31:0] xd;
    int          last, g, pct;
    do_reset();
    p0 = 0; p1 = 0; last = 1; xw = 0; xa = 0; xd = 0;
    for (int c = 0; c < 300; c++) begin
      if (c > 0) begin
        checks++;
        if (we !== xw || (xw && (wa !== xa || wd !== xd))) begin
          errors++;
          $display("FAIL b2b_write_%0d: got we=%b addr=%0d data=%h required %b,%0d,%h",
                   c, we, wa, wd, xw, xa, xd);
        end
      end
      pct = (c < 40) ? 100 : 60;
      if (!p0 && $urandom_range(99) < pct) begin
        p0 = 1; r0a = 5'($urandom_range(31)); r0d = $urandom;
      end
      if (!p1 && $urandom_range(99) < pct) begin
        p1 = 1; r1a = 5'($urandom_range(31)); r1d = $urandom;
      end
      r0v = p0; r1v = p1;
      #1;
      if (p0 && p1) g = (last == 1) ? 0 : 1;
      else if (p0)  g = 0;
      else if (p1)  g = 1;
      else          g = -1;
      checks++;
      if (r0r !== (g == 0) || r1r !== (g == 1)) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b%b required grant %0d", c, r0r, r1r, g);
      end
      xw = 0;
      if (g == 0) begin
        xw = (r0a != 0); xa = r0a; xd = r0d; p0 = 0; last = 0;
      end else if (g == 1) begin
        xw = (r1a != 0); xa = r1a; xd = r1d; p1 = 0; last = 1;
      end
      @(posedge CLK); #1;
    end
    r0v = 0; r1v = 0;
  endtask

  initial begin
    r0v = 0; r0a = 0; r0d = 0; r1v = 0; r1a = 0; r1d = 0;
    f0v = 0; f0a = 0; f0d = 0; f1v = 0; f1a = 0; f1d = 0;
    test_reset();
`ifdef REGFILE_CLEAR_EN
    test_sweep();
`endif
    test_single();
    test_zero_addr();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
